pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 20 ++
 rtl/hazard_cmp.sv | 24 ++
 rtl/pipeline_ctrl.sv | 138 +++++++++++++
 tb/tb_pipeline_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_MD_WAIT = 1'b1
    } state_t;

    localparam int         MD_TIMEOUT_DEF = 40;
    localparam logic [4:0] REG_ZERO       = 5'd0;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            return v;
        end else begin
            return v + 16'd1;
        end
    endfunction

endpackage

// File: rtl/hazard_cmp.sv
// Load-use hazard detector: the D-stage instruction reads the register the
// load in X is about to write. Register 0 never carries a dependency.
module hazard_cmp
    import pipe_ctrl_pkg::*;
(
    input  logic       i_d_valid,
    input  logic [4:0] i_d_rs,
    input  logic [4:0] i_d_rt,
    input  logic       i_d_use_rs,
    input  logic       i_d_use_rt,
    input  logic       i_x_load,
    input  logic [4:0] i_x_rd,
    output logic       o_hazard
);

    logic w_rs_match;
    logic w_rt_match;

    assign w_rs_match = i_d_use_rs && (i_d_rs == i_x_rd);
    assign w_rt_match = i_d_use_rt && (i_d_rt == i_x_rd);
    assign o_hazard   = i_x_load && (i_x_rd != REG_ZERO) && i_d_valid
                        && (w_rs_match || w_rt_match);

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline controller: branch flush, load-use interlock and mult/div handshake
// with a timeout watchdog, plus a saturating count of stalled cycles.
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MD_TIMEOUT = MD_TIMEOUT_DEF
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        d_valid,
    input  logic [4:0]  d_rs,
    input  logic [4:0]  d_rt,
    input  logic        d_use_rs,
    input  logic        d_use_rt,
    input  logic        d_md,
    input  logic        x_load,
    input  logic [4:0]  x_rd,
    input  logic        x_redirect,
    input  logic        md_rdy,
    input  logic        stat_clr,
    output logic        stall_fd,
    output logic        bubble_x,
    output logic        flush_fd,
    output logic        md_start,
    output logic        md_busy,
    output logic        md_timeout,
    output logic [15:0] stall_cnt
);

    localparam int              TO_W    = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MD_TIMEOUT - 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [TO_W-1:0] r_to_cnt;
    logic [TO_W-1:0] w_to_cnt_nxt;
    logic            r_md_timeout;
    logic            w_to_fire;
    logic [15:0]     r_stall_cnt;
    logic            w_hazard;

    hazard_cmp u_hazard_cmp (
        .i_d_valid  (d_valid),
        .i_d_rs     (d_rs),
        .i_d_rt     (d_rt),
        .i_d_use_rs (d_use_rs),
        .i_d_use_rt (d_use_rt),
        .i_x_load   (x_load),
        .i_x_rd     (x_rd),
        .o_hazard   (w_hazard)
    );

    // Next-state decode and same-cycle stall/flush responses
    always_comb begin
        w_state_nxt  = r_state;
        w_to_cnt_nxt = r_to_cnt;
        w_to_fire    = 1'b0;
        stall_fd     = 1'b0;
        bubble_x     = 1'b0;
        flush_fd     = 1'b0;
        md_start     = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (x_redirect) begin
                    flush_fd = 1'b1;
                end else if (w_hazard) begin
                    stall_fd = 1'b1;
                    bubble_x = 1'b1;
                end else if (d_valid && d_md) begin
                    md_start     = 1'b1;
                    stall_fd     = 1'b1;
                    bubble_x     = 1'b1;
                    w_state_nxt  = ST_MD_WAIT;
                    w_to_cnt_nxt = {TO_W{1'b0}};
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_MD_WAIT: begin
                // A result arriving on the watchdog's last cycle still counts as an answer
                if (md_rdy) begin
                    w_state_nxt = ST_RUN;
                end else if (r_to_cnt == TO_LAST) begin
                    w_to_fire   = 1'b1;
                    w_state_nxt = ST_RUN;
                end else begin
                    stall_fd     = 1'b1;
                    bubble_x     = 1'b1;
                    w_to_cnt_nxt = r_to_cnt + TO_W'(1);
                end
            end
            default: begin
                w_state_nxt  = ST_RUN;
                w_to_cnt_nxt = {TO_W{1'b0}};
            end
        endcase
    end

    // FSM state and watchdog counter
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_RUN;
            r_to_cnt <= {TO_W{1'b0}};
        end else begin
            r_state  <= w_state_nxt;
            r_to_cnt <= w_to_cnt_nxt;
        end
    end

    // Sticky record that the mult/div unit failed to answer
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_md_timeout <= 1'b0;
        end else if (w_to_fire) begin
            r_md_timeout <= 1'b1;
        end else begin
            r_md_timeout <= r_md_timeout;
        end
    end

    // Saturating stall statistics; clear takes precedence over counting
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cnt <= 16'd0;
        end else if (stat_clr) begin
            r_stall_cnt <= 16'd0;
        end else if (stall_fd) begin
            r_stall_cnt <= sat_inc16(r_stall_cnt);
        end else begin
            r_stall_cnt <= r_stall_cnt;
        end
    end

    assign md_busy    = (r_state == ST_MD_WAIT);
    assign md_timeout = r_md_timeout;
    assign stall_cnt  = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model.
module tb_pipeline_ctrl;

    localparam int MD_TO = 40;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        d_valid, d_use_rs, d_use_rt, d_md, x_load, x_redirect, md_rdy, stat_clr;
    logic [4:0]  d_rs, d_rt, x_rd;
    logic        stall_fd, bubble_x, flush_fd, md_start, md_busy, md_timeout;
    logic [15:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    // Behavioural model state: waiting flag, cycles already waited, sticky timeout, stall count
    bit m_waiting;
    int m_wait_cycles;
    bit m_to;
    int m_stalls;
    bit e_stall, e_bubble, e_flush, e_start, e_busy;

    pipeline_ctrl #(.MD_TIMEOUT(MD_TO)) dut (
        .clock(clock), .reset_n(reset_n), .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt),
        .d_use_rs(d_use_rs), .d_use_rt(d_use_rt), .d_md(d_md), .x_load(x_load),
        .x_rd(x_rd), .x_redirect(x_redirect), .md_rdy(md_rdy), .stat_clr(stat_clr),
        .stall_fd(stall_fd), .bubble_x(bubble_x), .flush_fd(flush_fd),
        .md_start(md_start), .md_busy(md_busy), .md_timeout(md_timeout),
        .stall_cnt(stall_cnt)
    );

    always #5 clock = ~clock;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle();
        d_valid = 1'b0; d_rs = 5'd0; d_rt = 5'd0; d_use_rs = 1'b0; d_use_rt = 1'b0;
        d_md = 1'b0; x_load = 1'b0; x_rd = 5'd0; x_redirect = 1'b0; md_rdy = 1'b0;
        stat_clr = 1'b0;
    endtask

    task automatic model_reset();
        m_waiting = 1'b0; m_wait_cycles = 0; m_to = 1'b0; m_stalls = 0;
    endtask

    task automatic model_eval();
        bit haz;
        haz = x_load && (x_rd != 5'd0) && d_valid &&
              ((d_use_rs && d_rs == x_rd) || (d_use_rt && d_rt == x_rd));
        e_busy = m_waiting; e_stall = 1'b0; e_bubble = 1'b0; e_flush = 1'b0; e_start = 1'b0;
        if (!m_waiting) begin
            if (x_redirect) e_flush = 1'b1;
            else if (haz) begin e_stall = 1'b1; e_bubble = 1'b1; end
            else if (d_valid && d_md) begin e_start = 1'b1; e_stall = 1'b1; e_bubble = 1'b1; end
        end else if (!md_rdy && (m_wait_cycles + 1 < MD_TO)) begin
            e_stall = 1'b1; e_bubble = 1'b1;
        end
    endtask

    task automatic model_commit();
        if (stat_clr) m_stalls = 0;
        else if (e_stall && m_stalls < 65535) m_stalls = m_stalls + 1;
        if (!m_waiting) begin
            if (e_start) begin m_waiting = 1'b1; m_wait_cycles = 0; end
        end else if (md_rdy) begin
            m_waiting = 1'b0;
        end else if (m_wait_cycles + 1 >= MD_TO) begin
            m_waiting = 1'b0; m_to = 1'b1;
        end else begin
            m_wait_cycles = m_wait_cycles + 1;
        end
    endtask

    task automatic settle();
        #3;
        model_eval();
    endtask

    task automatic advance();
        @(posedge clock);
        model_commit();
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        idle();
        model_reset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        idle();
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #2;
        checks++; if ({stall_fd, bubble_x, flush_fd, md_start} !== 4'b0000) begin errors++;
            $display("FAIL reset_comb: got %b expected 0000", {stall_fd, bubble_x, flush_fd, md_start}); end
        checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", md_busy); end
        checks++; if (md_timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b expected 0", md_timeout); end
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0h expected 0", stall_cnt); end
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        model_reset();
        settle();
        checks++; if ({stall_fd, bubble_x, flush_fd, md_start, md_busy} !== 5'b00000) begin errors++;
            $display("FAIL post_reset_idle: got %b expected 00000", {stall_fd, bubble_x, flush_fd, md_start, md_busy}); end
        advance();
    endtask

    task automatic test_load_use();
        idle();
        x_load = 1'b1; x_rd = 5'd5; d_rs = 5'd5; d_use_rs = 1'b1; d_valid = 1'b1; d_md = 1'b1;
        settle();
        checks++; if ({stall_fd, bubble_x, md_start, flush_fd} !== 4'b1100) begin errors++;
            $display("FAIL load_use: got %b expected 1100", {stall_fd, bubble_x, md_start, flush_fd}); end
        advance();
        idle();
        settle();
        checks++; if (stall_fd !== 1'b0) begin errors++; $display("FAIL load_use_once: got %b expected 0", stall_fd); end
        checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL load_use_cnt: got %0d expected 1", stall_cnt); end
        advance();
    endtask

    task automatic test_reg0_redirect();
        idle();
        x_load = 1'b1; x_rd = 5'd0; d_rs = 5'd0; d_rt = 5'd0;
        d_use_rs = 1'b1; d_use_rt = 1'b1; d_valid = 1'b1;
        settle();
        checks++; if ({stall_fd, bubble_x} !== 2'b00) begin errors++;
            $display("FAIL reg0_no_hazard: got %b expected 00", {stall_fd, bubble_x}); end
        x_rd = 5'd5; d_rs = 5'd5; x_redirect = 1'b1; d_md = 1'b1;
        settle();
        checks++; if ({flush_fd, stall_fd, bubble_x, md_start} !== 4'b1000) begin errors++;
            $display("FAIL redirect_prio: got %b expected 1000", {flush_fd, stall_fd, bubble_x, md_start}); end
        advance();
        idle();
        settle();
        checks++; if (md_busy !== 1'b0 || flush_fd !== 1'b0) begin errors++;
            $display("FAIL redirect_after: got busy=%b flush=%b expected 0 0", md_busy, flush_fd); end
        checks++; if (stall_cnt !== 16'(m_stalls)) begin errors++;
            $display("FAIL redirect_cnt: got %0d expected %0d", stall_cnt, m_stalls); end
        advance();
    endtask

    task automatic test_md_done();
        int busy_n = 0;
        int start_n = 0;
        do_reset();
        d_valid = 1'b1; d_md = 1'b1;
        settle();
        checks++; if ({md_start, stall_fd, bubble_x} !== 3'b111) begin errors++;
            $display("FAIL md_start: got %b expected 111", {md_start, stall_fd, bubble_x}); end
        start_n++;
        advance();
        for (int c = 1; c <= 8; c++) begin
            md_rdy = (c == 8);
            x_redirect = (c == 3);
            settle();
            if (md_busy) busy_n++;
            if (md_start) start_n++;
            checks++; if (stall_fd !== e_stall || bubble_x !== e_bubble || flush_fd !== 1'b0) begin errors++;
                $display("FAIL md_wait_c%0d: got %b%b%b expected %b%b0", c, stall_fd, bubble_x, flush_fd, e_stall, e_bubble); end
            advance();
        end
        idle();
        settle();
        checks++; if (busy_n != 8) begin errors++; $display("FAIL md_busy_len: got %0d expected 8", busy_n); end
        checks++; if (start_n != 1) begin errors++; $display("FAIL md_start_pulses: got %0d expected 1", start_n); end
        checks++; if (md_busy !== 1'b0 || md_timeout !== 1'b0) begin errors++;
            $display("FAIL md_done_state: got busy=%b to=%b expected 0 0", md_busy, md_timeout); end
        checks++; if (stall_cnt !== 16'd8) begin errors++; $display("FAIL md_done_cnt: got %0d expected 8", stall_cnt); end
        advance();
    endtask

    task automatic test_md_timeout();
        int n = 0;
        bit done = 1'b0;
        bit last_stall = 1'b1;
        do_reset();
        d_valid = 1'b1; d_md = 1'b1;
        settle();
        advance();
        for (int c = 0; c < 100 && !done; c++) begin
            settle();
            if (!md_busy) begin
                done = 1'b1;
            end else begin
                n++;
                last_stall = stall_fd;
                checks++; if (md_timeout !== 1'b0) begin errors++;
                    $display("FAIL md_to_early: got %b expected 0 at wait cycle %0d", md_timeout, n); end
                advance();
            end
        end
        idle();
        settle();
        checks++; if (!done) begin errors++; $display("FAIL md_to_bound: got busy after 100 cycles expected release"); end
        checks++; if (n != MD_TO) begin errors++; $display("FAIL md_to_len: got %0d expected %0d", n, MD_TO); end
        checks++; if (last_stall !== 1'b0) begin errors++; $display("FAIL md_to_release: got %b expected 0", last_stall); end
        checks++; if (md_timeout !== 1'b1 || md_busy !== 1'b0) begin errors++;
            $display("FAIL md_to_flag: got to=%b busy=%b expected 1 0", md_timeout, md_busy); end
        advance();
    endtask

    task automatic test_md_race();
        do_reset();
        d_valid = 1'b1; d_md = 1'b1;
        settle();
        advance();
        for (int c = 0; c < MD_TO; c++) begin
            md_rdy = (c == MD_TO - 1);
            settle();
            advance();
        end
        idle();
        settle();
        checks++; if (md_timeout !== 1'b0 || md_busy !== 1'b0) begin errors++;
            $display("FAIL md_race: got to=%b busy=%b expected 0 0", md_timeout, md_busy); end
        advance();
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        d_valid = 1'b1; d_md = 1'b1;
        settle();
        advance();
        repeat (3) begin settle(); advance(); end
        settle();
        checks++; if (md_busy !== 1'b1 || stall_cnt !== 16'd4) begin errors++;
            $display("FAIL mid_wait_pre: got busy=%b cnt=%0d expected 1 4", md_busy, stall_cnt); end
        idle();
        #2 reset_n = 1'b0;
        #1;
        checks++; if (md_busy !== 1'b0 || stall_cnt !== 16'd0 || md_timeout !== 1'b0) begin errors++;
            $display("FAIL async_reset: got busy=%b cnt=%0d to=%b expected 0 0 0", md_busy, stall_cnt, md_timeout); end
        do_reset();
        for (int c = 0; c < 4; c++) begin
            settle();
            checks++; if (md_start !== 1'b0 || md_busy !== 1'b0 || stall_fd !== 1'b0) begin errors++;
                $display("FAIL no_reissue_c%0d: got start=%b busy=%b stall=%b expected 0 0 0", c, md_start, md_busy, stall_fd); end
            advance();
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            d_valid = ($urandom_range(0, 3) != 0);
            d_rs = 5'($urandom_range(0, 3)); d_rt = 5'($urandom_range(0, 3));
            d_use_rs = 1'($urandom_range(0, 1)); d_use_rt = 1'($urandom_range(0, 1));
            d_md = ($urandom_range(0, 7) == 0);
            x_load = 1'($urandom_range(0, 1)); x_rd = 5'($urandom_range(0, 3));
            x_redirect = ($urandom_range(0, 7) == 0);
            md_rdy = ($urandom_range(0, 15) == 0);
            stat_clr = ($urandom_range(0, 31) == 0);
            settle();
            checks++; if ({stall_fd, bubble_x, flush_fd, md_start} !== {e_stall, e_bubble, e_flush, e_start}) begin errors++;
                $display("FAIL rnd_comb cyc %0d: got %b expected %b", i, {stall_fd, bubble_x, flush_fd, md_start}, {e_stall, e_bubble, e_flush, e_start}); end
            checks++; if (md_busy !== e_busy || md_timeout !== m_to) begin errors++;
                $display("FAIL rnd_state cyc %0d: got busy=%b to=%b expected %b %b", i, md_busy, md_timeout, e_busy, m_to); end
            checks++; if (stall_cnt !== 16'(m_stalls)) begin errors++;
                $display("FAIL rnd_cnt cyc %0d: got %0d expected %0d", i, stall_cnt, m_stalls); end
            advance();
        end
        idle();
    endtask

    task automatic test_saturate();
        do_reset();
        x_load = 1'b1; x_rd = 5'd7; d_rt = 5'd7; d_use_rt = 1'b1; d_valid = 1'b1;
        repeat (70000) @(posedge clock);
        #1;
        checks++; if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_cnt: got %0h expected ffff", stall_cnt); end
        stat_clr = 1'b1;
        @(posedge clock); #1;
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL sat_clr: got %0h expected 0", stall_cnt); end
        stat_clr = 1'b0;
        @(posedge clock); #1;
        checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL sat_restart: got %0h expected 1", stall_cnt); end
        idle();
    endtask

    initial begin
        idle();
        model_reset();
        test_reset();
        test_load_use();
        test_reg0_redirect();
        test_md_done();
        test_md_timeout();
        test_md_race();
        test_reset_mid_wait();
        test_random();
        test_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
